serial_compare_ctrl: RTL and testbench

//   Sequencer that performs one MSB-first serial magnitude compare of two parallel WIDTH-bit words.

---
 rtl/serial_compare_ctrl.sv | 105 ++++++++++
 tb/tb_serial_compare_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl: sequences one MSB-first serial magnitude compare through an external SerialComparator
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset (0 = reset)
//   start      compare request, accepted only when idle
//   a_word     operand A, sampled on the accepting edge
//   b_word     operand B, sampled on the accepting edge
//   busy       high from the accepting edge until the done cycle ends
//   done       one-cycle pulse, results valid from this cycle on
//   result_lt  A < B, held until the next capture
//   result_gt  A > B, held until the next capture
//   result_eq  A == B, held until the next capture
//   cmp_err    captured comparator flags were not one-hot, held
//   cmp_reset  synchronous clear to the comparator (active high)
//   cmp_a      serial bit of A to the comparator
//   cmp_b      serial bit of B to the comparator
//   cmp_lt     comparator lt flag
//   cmp_gt     comparator gt flag
//   cmp_eq     comparator eq flag
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             busy,
  output logic             done,
  output logic             result_lt,
  output logic             result_gt,
  output logic             result_eq,
  output logic             cmp_err,
  output logic             cmp_reset,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_lt,
  input  logic             cmp_gt,
  input  logic             cmp_eq
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, CAPTURE, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0]    cnt;
  logic             flags_bad;
  assign flags_bad = (2'(cmp_lt) + 2'(cmp_gt) + 2'(cmp_eq)) != 2'd1;
  // cmp_a/cmp_b are registered one step ahead so they always equal the MSB of the
  // shift registers while in SHIFT, and 0 everywhere else
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lt <= 1'b0;
      result_gt <= 1'b0;
      result_eq <= 1'b0;
      cmp_err   <= 1'b0;
      cmp_reset <= 1'b1;
      cmp_a     <= 1'b0;
      cmp_b     <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (start) begin
            a_sh  <= a_word;
            b_sh  <= b_word;
            cnt   <= CW'(WIDTH - 1);
            busy  <= 1'b1;
            state <= CLEAR;
          end
        CLEAR: begin
          cmp_reset <= 1'b0;
          cmp_a     <= a_sh[WIDTH-1];
          cmp_b     <= b_sh[WIDTH-1];
          state     <= SHIFT;
        end
        SHIFT: begin
          a_sh  <= {a_sh[WIDTH-2:0], 1'b0};
          b_sh  <= {b_sh[WIDTH-2:0], 1'b0};
          cnt   <= cnt - 1'b1;
          cmp_a <= (cnt != '0) & a_sh[WIDTH-2];
          cmp_b <= (cnt != '0) & b_sh[WIDTH-2];
          state <= (cnt == '0) ? CAPTURE : SHIFT;
        end
        CAPTURE: begin
          result_lt <= cmp_lt;
          result_gt <= cmp_gt;
          result_eq <= cmp_eq;
          cmp_err   <= flags_bad;
          done      <= 1'b1;
          cmp_reset <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// tb_serial_compare_ctrl: directed checks of serial_compare_ctrl at WIDTH=3 and WIDTH=8 against a behavioural SerialComparator
module tb_serial_compare_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic       start3 = 1'b0, start8 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy3, done3, lt3, gt3, eq3, err3, cr3, ca3, cb3;
  logic       busy8, done8, lt8, gt8, eq8, err8, cr8, ca8, cb8;
  logic [2:0] c3, c8;
  logic       f3 = 1'b0;
  int checks = 0, errors = 0;
  logic [2:0] p_res = '0;
  logic       p_err = 1'b0;

  serial_compare_ctrl #(.WIDTH(3)) u3 (
    .clk(clk), .reset(reset), .start(start3), .a_word(a3), .b_word(b3),
    .busy(busy3), .done(done3), .result_lt(lt3), .result_gt(gt3), .result_eq(eq3),
    .cmp_err(err3), .cmp_reset(cr3), .cmp_a(ca3), .cmp_b(cb3),
    .cmp_lt(c3[2] | f3), .cmp_gt(c3[1] | f3), .cmp_eq(c3[0]));
  serial_compare_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .a_word(a8), .b_word(b8),
    .busy(busy8), .done(done8), .result_lt(lt8), .result_gt(gt8), .result_eq(eq8),
    .cmp_err(err8), .cmp_reset(cr8), .cmp_a(ca8), .cmp_b(cb8),
    .cmp_lt(c8[2]), .cmp_gt(c8[1]), .cmp_eq(c8[0]));

  // behavioural SerialComparator: flags {lt,gt,eq}, first differing bit decides
  always_ff @(posedge clk)
    if (cr3) c3 <= 3'b001;
    else if (c3[0] && ca3 != cb3) c3 <= ca3 ? 3'b010 : 3'b100;
  always_ff @(posedge clk)
    if (cr8) c8 <= 3'b001;
    else if (c8[0] && ca8 != cb8) c8 <= ca8 ? 3'b010 : 3'b100;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] res;
    logic       err;
    int         force_n;
  } vec_t;
  vec_t tv[6];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic op3(input vec_t v);
    int n, bc, lat, crbad;
    logic [2:0] sa, sb;
    @(negedge clk);
    a3 = v.a; b3 = v.b; start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0; a3 = ~v.a; b3 = ~v.b;
    n = 0; bc = 0; lat = -1; crbad = 0; sa = '0; sb = '0;
    while (n < 40 && lat < 0) begin
      @(negedge clk);
      if (n == 0) begin
        chk("w3_hold_res", {lt3, gt3, eq3}, p_res);
        chk("w3_hold_err", err3, p_err);
        if (!cr3) crbad++;
      end
      if (n >= 1 && n <= 3) begin
        sa[3-n] = ca3;
        sb[3-n] = cb3;
        if (cr3) crbad++;
      end
      f3 = (n == v.force_n);
      if (busy3) bc++;
      if (done3) lat = n;
      else begin
        @(posedge clk);
        n++;
      end
    end
    f3 = 1'b0;
    chk("w3_latency", lat, 5);
    chk("w3_busy_cycles", bc, 6);
    chk("w3_serial_a", sa, v.a);
    chk("w3_serial_b", sb, v.b);
    chk("w3_cmp_reset_seq", crbad, 0);
    chk("w3_result", {lt3, gt3, eq3}, v.res);
    chk("w3_err", err3, v.err);
    @(posedge clk);
    @(negedge clk);
    chk("w3_idle_after", {busy3, done3, cr3}, 3'b001);
    p_res = v.res;
    p_err = v.err;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] res);
    int n, lat;
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    n = 0; lat = -1;
    while (n < 40 && lat < 0) begin
      @(negedge clk);
      if (done8) lat = n;
      else begin
        @(posedge clk);
        n++;
      end
    end
    chk("w8_latency", lat, 10);
    chk("w8_result", {lt8, gt8, eq8}, res);
    chk("w8_err", err8, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, d1, d2, unstable;
    logic [2:0] r1;
    tv[0] = '{3'b110, 3'b101, 3'b010, 1'b0, -1};
    tv[1] = '{3'b111, 3'b111, 3'b001, 1'b0, -1};
    tv[2] = '{3'b000, 3'b001, 3'b100, 1'b0, -1};
    tv[3] = '{3'b011, 3'b100, 3'b100, 1'b0, -1};
    tv[4] = '{3'b110, 3'b101, 3'b110, 1'b1, 4};
    tv[5] = '{3'b111, 3'b111, 3'b001, 1'b0, -1};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_w3_outs", {busy3, done3, lt3, gt3, eq3, err3, ca3, cb3}, 8'h00);
    chk("rst_w3_cmp_reset", cr3, 1'b1);
    chk("rst_w8_outs", {busy8, done8, lt8, gt8, eq8, err8, ca8, cb8}, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_w3", {busy3, done3, cr3, ca3}, 4'b0010);
    foreach (tv[i]) op3(tv[i]);

    // start held high: 0x80 vs 0x7F, then 0x12 vs 0x12 accepted at E12
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h7F; start8 = 1'b1;
    @(posedge clk);
    #1 a8 = 8'h12; b8 = 8'h12;
    n = 0; d1 = -1; d2 = -1; unstable = 0; r1 = '0;
    while (n < 40 && d2 < 0) begin
      @(negedge clk);
      if (n == 12) start8 = 1'b0;
      if (done8 && d1 >= 0) d2 = n;
      else if (done8) begin
        d1 = n;
        r1 = {lt8, gt8, eq8};
      end else if (d1 >= 0 && {lt8, gt8, eq8} != 3'b010) unstable++;
      if (d2 < 0) begin
        @(posedge clk);
        n++;
      end
    end
    chk("held_first_done", d1, 10);
    chk("held_first_res", r1, 3'b010);
    chk("held_second_done", d2, 22);
    chk("held_second_res", {lt8, gt8, eq8}, 3'b001);
    chk("held_res_stable", unstable, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("held_no_extra_op", {busy8, done8}, 2'b00);

    // reset during the third SHIFT cycle
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midop_busy", busy8, 1'b1);
    reset = 1'b0;
    #1;
    chk("midop_rst_outs", {busy8, done8, lt8, gt8, eq8, err8, ca8, cb8}, 8'h00);
    chk("midop_rst_cmp_reset", cr8, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    op8(8'h01, 8'h02, 3'b100);
    op8(8'hA5, 8'hA4, 3'b010);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
